// File: rtl/irq_scheduler_pkg.sv
// Shared types and constants for the interrupt priority scheduler.
package irq_scheduler_pkg;

    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    localparam logic [2:0] REG_PRIO0  = 3'd0;
    localparam logic [2:0] REG_PRIO1  = 3'd1;
    localparam logic [2:0] REG_PRIO2  = 3'd2;
    localparam logic [2:0] REG_PRIO3  = 3'd3;
    localparam logic [2:0] REG_THRESH = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    typedef logic [PRIO_W-1:0] prio_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        REQ   = 2'd2,
        CLAIM = 2'd3
    } state_t;

endpackage

// File: rtl/irq_prio_tree.sv
// Combinational max-priority selector over the eligible sources.
// Ties resolve to the lowest source index.
module irq_prio_tree
    import irq_scheduler_pkg::*;
#(
    parameter int NUM_SRC = 32
)(
    input  logic [NUM_SRC-1:0]        elig_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic                      valid_o,
    output logic [ID_W-1:0]           id_o,
    output logic [PRIO_W-1:0]         prio_o
);

    always_comb begin : tree
        logic            vld_n [NUM_SRC];
        prio_t           pri_n [NUM_SRC];
        logic [ID_W-1:0] idx_n [NUM_SRC];
        int              s;
        int              i;

        for (int k = 0; k < NUM_SRC; k++) begin
            vld_n[k] = elig_i[k];
            pri_n[k] = prio_i[k*PRIO_W +: PRIO_W];
            idx_n[k] = ID_W'(k);
        end

        // Pairwise reduction: the left (lower-index) node keeps ties.
        for (int lvl = 0; lvl < $clog2(NUM_SRC); lvl++) begin
            s = 1 << lvl;
            for (int k = 0; k < NUM_SRC / 2; k++) begin
                i = k * 2 * s;
                if (i + s < NUM_SRC) begin
                    if (vld_n[i+s] && (!vld_n[i] || (pri_n[i+s] > pri_n[i]))) begin
                        vld_n[i] = 1'b1;
                        pri_n[i] = pri_n[i+s];
                        idx_n[i] = idx_n[i+s];
                    end
                end
            end
        end

        valid_o = vld_n[0];
        id_o    = idx_n[0];
        prio_o  = pri_n[0];
    end

endmodule

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: APB-programmed priorities/threshold, req/ack to the core, one-hot clear back.
// Optional build macro IRQ_SCHED_PREEMPT_EN lets a strictly higher-priority source replace a pending request.
module irq_scheduler
    import irq_scheduler_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_SRC        = 32
)(
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_SRC-1:0]        pending_i,
    output logic                      irq_req_o,
    output logic [ID_W-1:0]           irq_id_o,
    input  logic                      irq_ack_i,
    output logic [NUM_SRC-1:0]        clear_o
);

    prio_t                     prio_q [NUM_SRC];
    prio_t                     prio_d [NUM_SRC];
    prio_t                     thresh_q, thresh_d;
    state_t                    state_q, state_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [ID_W-1:0]           last_ack_q, last_ack_d;
    logic                      req_q, req_d;
    logic [NUM_SRC-1:0]        clear_q, clear_d;

    logic [NUM_SRC-1:0]        elig;
    logic [NUM_SRC*PRIO_W-1:0] prio_flat;
    logic                      win_vld;
    logic [ID_W-1:0]           win_id;
    prio_t                     win_prio;
    logic [2:0]                reg_idx;
    logic                      apb_wr;
    logic                      apb_rd;
    logic                      unused_ok;

    assign reg_idx   = PADDR[4:2];
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign irq_req_o = req_q;
    assign irq_id_o  = id_q;
    assign clear_o   = clear_q;
    assign unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA[31], PWDATA[27],
                         PWDATA[23], PWDATA[19], PWDATA[15], PWDATA[11], PWDATA[7],
                         PWDATA[3], win_prio};

    always_comb begin
        prio_d   = prio_q;
        thresh_d = thresh_q;
        if (apb_wr) begin
            if (reg_idx <= REG_PRIO3) begin
                for (int j = 0; j < 8; j++)
                    prio_d[{reg_idx[1:0], 3'(j)}] = PWDATA[4*j +: PRIO_W];
            end else if (reg_idx == REG_THRESH) begin
                thresh_d = PWDATA[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pending_i[i] && (prio_q[i] > thresh_q);
            prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
        end
    end

    irq_prio_tree #(.NUM_SRC(NUM_SRC)) u_tree (
        .elig_i  (elig),
        .prio_i  (prio_flat),
        .valid_o (win_vld),
        .id_o    (win_id),
        .prio_o  (win_prio)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        req_d      = req_q;
        clear_d    = '0;
        last_ack_d = last_ack_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (elig[id_q]) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Ack outranks a same-cycle withdraw.
                if (irq_ack_i) begin
                    state_d       = CLAIM;
                    req_d         = 1'b0;
                    clear_d[id_q] = 1'b1;
                    last_ack_d    = id_q;
                end else if (!elig[id_q]) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
`ifdef IRQ_SCHED_PREEMPT_EN
                else if (win_vld && (win_prio > prio_q[id_q])) begin
                    id_d = win_id;
                end
`endif
            end
            CLAIM:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        PRDATA = '0;
        if (apb_rd) begin
            if (reg_idx <= REG_PRIO3) begin
                for (int j = 0; j < 8; j++)
                    PRDATA[4*j +: PRIO_W] = prio_q[{reg_idx[1:0], 3'(j)}];
            end else if (reg_idx == REG_THRESH) begin
                PRDATA[PRIO_W-1:0] = thresh_q;
            end else if (reg_idx == REG_STATUS) begin
                PRDATA[12:0] = {last_ack_q, req_q, id_q, state_q};
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            prio_q   <= '{default: '0};
            thresh_q <= '0;
        end else begin
            prio_q   <= prio_d;
            thresh_q <= thresh_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            id_q       <= '0;
            req_q      <= 1'b0;
            clear_q    <= '0;
            last_ack_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            req_q      <= req_d;
            clear_q    <= clear_d;
            last_ack_q <= last_ack_d;
        end
    end

endmodule

// File: tb/tb_irq_scheduler.sv
// Self-checking bench for irq_scheduler: vector table, directed corner sequences, random vs. reference model.
module tb_irq_scheduler;

    logic        HCLK;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] pending_i;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;
    logic [31:0] clear_o;

    int checks = 0;
    int errors = 0;

    irq_scheduler #(.APB_ADDR_WIDTH(12), .NUM_SRC(32)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .pending_i (pending_i),
        .irq_req_o (irq_req_o),
        .irq_id_o  (irq_id_o),
        .irq_ack_i (irq_ack_i),
        .clear_o   (clear_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock; the service unit drops any pending bit it saw cleared.
    task automatic tick();
        logic [31:0] pc;
        pc = clear_o;
        @(posedge HCLK);
        #1;
        pending_i = pending_i & ~pc;
    endtask

    task automatic do_reset();
        HRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        pending_i = '0; irq_ack_i = 0;
        tick(); tick();
        HRESET = 1'b0;
    endtask

    task automatic apb_write(input int idx, input logic [31:0] data);
        PADDR = 12'(idx * 4); PWDATA = data; PWRITE = 1; PSEL = 1; PENABLE = 0;
        tick();
        PENABLE = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic read_now(input int idx, output logic [31:0] d);
        PADDR = 12'(idx * 4); PWRITE = 0; PSEL = 1; PENABLE = 1;
        #1;
        d = PRDATA;
        PSEL = 0; PENABLE = 0;
    endtask

    // ---------------- reference model ----------------
    int          m_ph, m_id, m_last, thresh_m;
    bit          m_req;
    logic [31:0] m_clr;
    int          prio_m [32];

    function automatic bit m_elig(int i);
        return pending_i[i] && (prio_m[i] > thresh_m);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_id = 0; m_last = 0; m_req = 0; m_clr = '0; thresh_m = 0;
        for (int i = 0; i < 32; i++) prio_m[i] = 0;
    endtask

    task automatic model_step();
        int best, bp;
        best = -1; bp = 0;
        for (int i = 0; i < 32; i++)
            if (m_elig(i) && prio_m[i] > bp) begin best = i; bp = prio_m[i]; end
        m_clr = '0;
        case (m_ph)
            0: if (best >= 0) begin m_id = best; m_ph = 1; end
            1: begin
                if (m_elig(m_id)) begin m_ph = 2; m_req = 1; end
                else m_ph = 0;
            end
            2: begin
                if (irq_ack_i) begin
                    m_ph = 3; m_req = 0; m_clr = 32'(1) << m_id; m_last = m_id;
                end else if (!m_elig(m_id)) begin
                    m_ph = 0; m_req = 0;
                end
`ifdef IRQ_SCHED_PREEMPT_EN
                else if (best >= 0 && prio_m[best] > prio_m[m_id]) begin
                    m_id = best;
                end
`endif
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic model_write(input int idx, input logic [31:0] d);
        if (idx < 4) begin
            for (int j = 0; j < 8; j++) prio_m[8*idx + j] = int'((d >> (4*j)) & 32'h7);
        end else if (idx == 4) begin
            thresh_m = int'(d & 32'h7);
        end
    endtask

    function automatic logic [31:0] model_rd(int idx);
        logic [31:0] v;
        v = '0;
        if (idx < 4) begin
            for (int j = 0; j < 8; j++) v = v | (32'(prio_m[8*idx + j]) << (4*j));
        end else if (idx == 4) begin
            v = 32'(thresh_m);
        end else if (idx == 5) begin
            v = 32'(m_ph) + 32'(m_id) * 4 + 32'(m_req) * 128 + 32'(m_last) * 256;
        end
        return v;
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0][31:0] prio;
        logic [2:0]       thr;
        logic [31:0]      pend;
        logic             req;
        logic [4:0]       id;
    } vec_t;

    function automatic vec_t mk(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3,
                                logic [2:0] thr, logic [31:0] pend, logic req, logic [4:0] id);
        vec_t v;
        v.prio = {w3, w2, w1, w0};
        v.thr = thr; v.pend = pend; v.req = req; v.id = id;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        logic [31:0] rd;
        int          exp_id;

        vecs[0] = mk(32'h10, 0, 0, 0, 3'd0, 32'h2, 1'b1, 5'd1);
        vecs[1] = mk(32'h5000_5000, 0, 0, 0, 3'd0, 32'h88, 1'b1, 5'd3);
        vecs[2] = mk(32'h500, 0, 0, 0, 3'd5, 32'h4, 1'b0, 5'd0);
        vecs[3] = mk(32'h500, 0, 0, 0, 3'd4, 32'h4, 1'b1, 5'd2);
        vecs[4] = mk(0, 0, 0, 0, 3'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        vecs[5] = mk(32'h6, 0, 0, 32'h7000_0000, 3'd0, 32'h8000_0001, 1'b1, 5'd31);
        vecs[6] = mk(32'h7, 0, 0, 32'h7000_0000, 3'd0, 32'h8000_0001, 1'b1, 5'd0);
        vecs[7] = mk(32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 32'h7777_7777, 3'd7,
                     32'hFFFF_FFFF, 1'b0, 5'd0);
        vecs[8] = mk(32'h0310_0000, 0, 0, 0, 3'd0, 32'h20, 1'b1, 5'd5);
        vecs[9] = mk(32'h3, 32'h0004_0000, 32'h0004_0000, 0, 3'd0, 32'h0010_1001, 1'b1, 5'd12);

        // Reset state
        HRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        pending_i = '0; irq_ack_i = 0;
        #1;
        chk("rst_async_req", 32'(irq_req_o), 0);
        do_reset();
        chk("rst_req", 32'(irq_req_o), 0);
        chk("rst_id", 32'(irq_id_o), 0);
        chk("rst_clear", clear_o, 0);
        chk("rst_prdata_idle", PRDATA, 0);
        read_now(5, rd); chk("rst_status", rd, 0);
        read_now(0, rd); chk("rst_prio0", rd, 0);
        apb_write(4, 32'h3);
        PADDR = 12'(16); PWRITE = 0; PSEL = 1; PENABLE = 0; #1;
        chk("prdata_setup_phase", PRDATA, 0);
        PENABLE = 1; #1;
        chk("prdata_thresh", PRDATA, 32'h3);
        PSEL = 0; PENABLE = 0;

        // Table-driven arbitration vectors
        for (int k = 0; k < 10; k++) begin
            vec_t v;
            v = vecs[k];
            do_reset();
            for (int w = 0; w < 4; w++) apb_write(w, v.prio[w]);
            apb_write(4, 32'(v.thr));
            pending_i = v.pend;
            tick(); tick();
            chk($sformatf("vec%0d_req", k), 32'(irq_req_o), 32'(v.req));
            chk($sformatf("vec%0d_id", k), 32'(irq_id_o), 32'(v.id));
            if (v.req) begin
                irq_ack_i = 1; tick(); irq_ack_i = 0;
                chk($sformatf("vec%0d_clear", k), clear_o, 32'(1) << v.id);
                chk($sformatf("vec%0d_req_claim", k), 32'(irq_req_o), 0);
                tick();
                chk($sformatf("vec%0d_clear_end", k), clear_o, 0);
                read_now(5, rd);
                chk($sformatf("vec%0d_last_ack", k), (rd >> 8) & 32'h1F, 32'(v.id));
            end
            pending_i = '0;
            tick(); tick(); tick();
        end

        // Equal priority: id 3 first, then id 7 once 3 is cleared
        do_reset();
        apb_write(0, 32'h5000_5000);
        pending_i = 32'h88;
        tick(); tick();
        chk("tie_first_id", 32'(irq_id_o), 3);
        irq_ack_i = 1; tick(); irq_ack_i = 0;
        chk("tie_first_clear", clear_o, 32'h8);
        tick();
        chk("tie_idle_req", 32'(irq_req_o), 0);
        tick(); tick();
        chk("tie_second_req", 32'(irq_req_o), 1);
        chk("tie_second_id", 32'(irq_id_o), 7);
        irq_ack_i = 1; tick(); irq_ack_i = 0;
        chk("tie_second_clear", clear_o, 32'h80);
        tick();
        chk("tie_pending_dropped", pending_i, 0);

        // Threshold masks, then lowering it releases the request
        do_reset();
        apb_write(0, 32'h500);
        apb_write(4, 32'h5);
        pending_i = 32'h4;
        tick(); tick(); tick();
        chk("thresh_masked_req", 32'(irq_req_o), 0);
        apb_write(4, 32'h4);
        tick(); tick();
        chk("thresh_lowered_req", 32'(irq_req_o), 1);
        chk("thresh_lowered_id", 32'(irq_id_o), 2);

        // Withdraw: pending drops in REQ without ack
        do_reset();
        apb_write(0, 32'h0003_0000);
        pending_i = 32'h10;
        tick(); tick();
        chk("wd_req", 32'(irq_req_o), 1);
        chk("wd_id", 32'(irq_id_o), 4);
        pending_i = '0;
        tick();
        chk("wd_req_drop", 32'(irq_req_o), 0);
        chk("wd_no_clear", clear_o, 0);
        tick();
        chk("wd_no_clear2", clear_o, 0);

        // Ack and withdraw in the same cycle: ack wins
        pending_i = 32'h10;
        tick(); tick();
        chk("ackwd_req", 32'(irq_req_o), 1);
        irq_ack_i = 1; pending_i = '0;
        tick(); irq_ack_i = 0;
        chk("ackwd_clear", clear_o, 32'h10);
        tick();
        read_now(5, rd);
        chk("ackwd_status", rd, 32'h410);

        // Ack outside REQ is ignored
        irq_ack_i = 1;
        tick(); tick(); tick();
        irq_ack_i = 0;
        chk("stray_ack_clear", clear_o, 0);
        chk("stray_ack_req", 32'(irq_req_o), 0);

        // Higher-priority arrival while in REQ
        do_reset();
        apb_write(0, 32'h20);
        apb_write(1, 32'h60);
        pending_i = 32'h2;
        tick(); tick();
        chk("pre_req", 32'(irq_req_o), 1);
        chk("pre_id_before", 32'(irq_id_o), 1);
        pending_i = pending_i | 32'h200;
        tick(); tick();
`ifdef IRQ_SCHED_PREEMPT_EN
        exp_id = 9;
`else
        exp_id = 1;
`endif
        chk("pre_req_held", 32'(irq_req_o), 1);
        chk("pre_id_after", 32'(irq_id_o), 32'(exp_id));
        chk("pre_no_clear", clear_o, 0);
        irq_ack_i = 1; tick(); irq_ack_i = 0;
        chk("pre_clear", clear_o, 32'(1) << exp_id);
        pending_i = '0;
        tick(); tick();

        // Reset in the middle of REQ
        do_reset();
        apb_write(0, 32'h20);
        pending_i = 32'h2;
        tick(); tick();
        chk("rreq_req", 32'(irq_req_o), 1);
        #2; HRESET = 1'b1; #1;
        chk("rreq_req_async", 32'(irq_req_o), 0);
        chk("rreq_id_async", 32'(irq_id_o), 0);
        chk("rreq_clear", clear_o, 0);
        tick();
        chk("rreq_clear_after", clear_o, 0);
        HRESET = 1'b0;
        read_now(0, rd);
        chk("rreq_prio_cleared", rd, 0);
        pending_i = '0;

        // Register map corners
        apb_write(2, 32'hFFFF_FFFF);
        read_now(2, rd); chk("prio2_bit3_zero", rd, 32'h7777_7777);
        apb_write(4, 32'hFFFF_FFFF);
        read_now(4, rd); chk("thresh_width", rd, 32'h7);
        read_now(6, rd); chk("idx6_zero", rd, 0);
        apb_write(7, 32'hFFFF_FFFF);
        read_now(7, rd); chk("idx7_zero", rd, 0);
        read_now(3, rd); chk("idx7_write_ignored", rd, 0);
        apb_write(5, 32'hFFFF_FFFF);
        read_now(5, rd); chk("status_readonly", rd, 0);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int w = 0; w < 4; w++) begin
            logic [31:0] d;
            d = $urandom;
            apb_write(w, d);
            model_write(w, d);
        end
        for (int c = 0; c < 2500; c++) begin
            int          r, widx;
            logic [31:0] wdata;
            r = $urandom_range(0, 99);
            widx = -1;
            if ($urandom_range(0, 3) == 0) pending_i = pending_i | (32'(1) << $urandom_range(0, 31));
            if ($urandom_range(0, 11) == 0) pending_i = pending_i & ~(32'(1) << $urandom_range(0, 31));
            irq_ack_i = ($urandom_range(0, 3) == 0);
            if (r < 6) begin
                widx = $urandom_range(0, 4);
                wdata = (widx == 4) ? 32'($urandom_range(0, 5)) : $urandom;
                PADDR = 12'(widx * 4); PWDATA = wdata; PWRITE = 1; PSEL = 1; PENABLE = 1;
            end else if (r < 20) begin
                int ridx;
                ridx = $urandom_range(0, 7);
                read_now(ridx, rd);
                chk($sformatf("rnd%0d_prdata_idx%0d", c, ridx), rd, model_rd(ridx));
            end
            model_step();
            tick();
            if (widx >= 0) model_write(widx, wdata);
            PSEL = 0; PENABLE = 0; PWRITE = 0;
            chk($sformatf("rnd%0d_req", c), 32'(irq_req_o), 32'(m_req));
            chk($sformatf("rnd%0d_id", c), 32'(irq_id_o), 32'(m_id));
            chk($sformatf("rnd%0d_clear", c), clear_o, m_clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
